// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and helpers for the SRAM port arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Starvation counter width: must hold values 0..limit inclusive.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - data-priority fetch/data arbiter for one single-port SRAM
// Owner of each accepted access is pipelined one cycle so responses route with zero bubbles.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  STARVE_LIMIT = 4,
    localparam int NUM_BYTES    = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  i_req_i,
    input  logic [DATA_WIDTH-1:0] i_addr_i,
    output logic                  i_gnt_o,
    output logic                  i_rvalid_o,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_err_o,

    input  logic                  d_req_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [NUM_BYTES-1:0]  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic                  d_wvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,

    output logic                  m_req_o,
    output logic [DATA_WIDTH-1:0] m_addr_o,
    output logic [NUM_BYTES-1:0]  m_we_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    input  logic                  m_rvalid_i,
    input  logic                  m_wvalid_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    input  logic                  m_err_i,

    output logic                  proto_err_o
);

    localparam int             CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]     starve_q, starve_d;
    owner_e               owner_q, owner_d;
    logic [NUM_BYTES-1:0] we_q;
    logic                 proto_err_q;
    logic                 rst_d_q;
    logic                 force_fetch;

    always_comb begin
        force_fetch = (starve_q == LIMIT);
        d_gnt_o     = ~rst_i & d_req_i & ~(force_fetch & i_req_i);
        i_gnt_o     = ~rst_i & i_req_i & ~d_gnt_o;

        m_req_o   = i_gnt_o | d_gnt_o;
        m_addr_o  = d_gnt_o ? d_addr_i : (i_gnt_o ? i_addr_i : '0);
        m_we_o    = d_gnt_o ? d_we_i : '0;
        m_wdata_o = d_wdata_i;

        if (i_req_i && !i_gnt_o) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
        end else begin
            starve_d = '0;
        end

        if (d_gnt_o) begin
            owner_d = OWN_DATA;
        end else if (i_gnt_o) begin
            owner_d = OWN_INSTR;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Responses are suppressed while reset is held, even if the SRAM is still answering.
    always_comb begin
        i_rvalid_o = ~rst_i & (owner_q == OWN_INSTR) & m_rvalid_i;
        i_err_o    = ~rst_i & (owner_q == OWN_INSTR) & m_err_i;
        d_rvalid_o = ~rst_i & (owner_q == OWN_DATA) & m_rvalid_i & ~(|we_q);
        d_wvalid_o = ~rst_i & (owner_q == OWN_DATA) & m_wvalid_i;
        d_err_o    = ~rst_i & (owner_q == OWN_DATA) & m_err_i;
        i_rdata_o  = m_rdata_i;
        d_rdata_o  = m_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q     <= OWN_NONE;
            we_q        <= '0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
            rst_d_q     <= 1'b1;
        end else begin
            owner_q  <= owner_d;
            we_q     <= m_we_o;
            starve_q <= starve_d;
            rst_d_q  <= 1'b0;
            // A straggler response from before reset is expected in the first cycle out of it.
            if ((m_rvalid_i || m_wvalid_i) && owner_q == OWN_NONE && !rst_d_q) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench with SRAM model and response scoreboard
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_wvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_rvalid, m_wvalid, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_we;
    logic        proto_err;
    logic        inj;

    logic        s_rvalid, s_wvalid, s_err;
    logic [31:0] s_rdata;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    assign m_rvalid = s_rvalid | inj;
    assign m_wvalid = s_wvalid;
    assign m_rdata  = s_rdata;
    assign m_err    = s_err;

    sram_port_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid),
        .i_rdata_o(i_rdata), .i_err_o(i_err),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_wvalid_o(d_wvalid),
        .d_rdata_o(d_rdata), .d_err_o(d_err),
        .m_req_o(m_req), .m_addr_o(m_addr), .m_we_o(m_we), .m_wdata_o(m_wdata),
        .m_rvalid_i(m_rvalid), .m_wvalid_i(m_wvalid), .m_rdata_i(m_rdata), .m_err_i(m_err),
        .proto_err_o(proto_err)
    );

    function automatic logic [31:0] init_word(input int k);
        return 32'h5A5A_0000 + k * 32'h0001_0101;
    endfunction

    // SRAM wrapper: 1-cycle registered response, error outside 256 bytes
    always @(posedge clk) begin
        s_rvalid <= 1'b0;
        s_wvalid <= 1'b0;
        s_err    <= 1'b0;
        if (m_req) begin
            s_err <= (m_addr >= 32'd256);
            if (m_we != 4'h0) begin
                s_wvalid <= 1'b1;
                if (m_addr < 32'd256)
                    for (int b = 0; b < 4; b++)
                        if (m_we[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                s_rvalid <= 1'b1;
                s_rdata  <= (m_addr < 32'd256) ? mem[m_addr[7:2]] : 32'h0;
            end
        end
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [31:0] daddr;
        logic [3:0]  dwe;
        logic [31:0] dwdata;
        logic        eig;
        logic        edg;
    } vec_t;

    typedef struct {
        logic        port_d;
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] last_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_addr = v.daddr; d_we = v.dwe; d_wdata = v.dwdata;
        @(negedge clk);
        chk("i_gnt", {31'd0, i_gnt}, {31'd0, v.eig});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.edg});
        chk("m_req", {31'd0, m_req}, {31'd0, v.eig | v.edg});
        if (d_rvalid) last_d_rdata = d_rdata;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, ~e.port_d});
            chk("i_err", {31'd0, i_err}, {31'd0, ~e.port_d & e.err});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.port_d & ~e.wr});
            chk("d_wvalid", {31'd0, d_wvalid}, {31'd0, e.port_d & e.wr});
            chk("d_err", {31'd0, d_err}, {31'd0, e.port_d & e.err});
            if (!e.wr && !e.err) chk(e.port_d ? "d_rdata" : "i_rdata",
                                     e.port_d ? d_rdata : i_rdata, e.data);
        end else begin
            chk("idle_valids", {27'd0, i_rvalid, i_err, d_rvalid, d_wvalid, d_err}, 32'd0);
        end
        if (v.eig) begin
            e = '{1'b0, 1'b0, ref_mem[v.iaddr[7:2]], v.iaddr >= 32'd256};
            sb.push_back(e);
        end
        if (v.edg) begin
            e = '{1'b1, v.dwe != 4'h0, ref_mem[v.daddr[7:2]], v.daddr >= 32'd256};
            sb.push_back(e);
            if (v.dwe != 4'h0 && v.daddr < 32'd256)
                for (int b = 0; b < 4; b++)
                    if (v.dwe[b]) ref_mem[v.daddr[7:2]][8*b +: 8] = v.dwdata[8*b +: 8];
        end
    endtask

    vec_t tbl[14];
    vec_t v;
    logic [31:0] w2;

    initial begin
        for (int k = 0; k < 64; k++) begin
            mem[k]     = init_word(k);
            ref_mem[k] = init_word(k);
        end
        s_rvalid = 1'b0; s_wvalid = 1'b0; s_err = 1'b0; s_rdata = '0;
        rst = 1'b1; inj = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
        last_d_rdata = '0;

        tbl[0]  = '{1'b1, 32'h10,  1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'h10,  1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,  1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h14,  1'b1, 32'h20,  4'h0, 32'h0,         1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'h14,  1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 32'h8,   4'h3, 32'hAABBCCDD,  1'b0, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'h8,   4'h0, 32'h0,         1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 32'h4,   4'h0, 32'h0,         1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'hC,   4'hF, 32'h12345678,  1'b0, 1'b1};
        tbl[10] = '{1'b1, 32'hC,   1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 32'h400, 4'h0, 32'h0,         1'b0, 1'b1};
        tbl[12] = '{1'b1, 32'h300, 1'b0, 32'h0,   4'h0, 32'h0,         1'b1, 1'b0};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,         1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {25'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, d_wvalid, m_req, proto_err}, 32'd0);

        for (int r = 0; r < 14; r++) apply(tbl[r]);

        // readback of the partial write at 0x8
        apply('{1'b0, 32'h0, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 1'b1});
        apply(tbl[13]);
        w2 = init_word(2);
        chk("readback_low", {16'd0, last_d_rdata[15:0]}, 32'h0000CCDD);
        chk("readback_high", {16'd0, last_d_rdata[31:16]}, {16'd0, w2[31:16]});

        // starvation: fetch forced every fifth cycle
        for (int k = 0; k < 10; k++) begin
            v = '{1'b1, 32'h30, 1'b1, 32'h20 + 32'(4 * k), 4'h0, 32'h0, (k % 5) == 4, (k % 5) != 4};
            apply(v);
        end
        apply(tbl[13]);

        // reset the cycle after a grant: in-flight response is dropped
        apply('{1'b0, 32'h0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 1'b1});
        @(posedge clk);
        #1 rst = 1'b1; d_req = 1'b1; i_req = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {26'd0, i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, d_err}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0; d_req = 1'b0; i_req = 1'b0; inj = 1'b1;
        @(negedge clk);
        chk("post_rst_drop", {29'd0, i_rvalid, d_rvalid, proto_err}, 32'd0);
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("proto_err_masked", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("proto_err_set", {31'd0, proto_err}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("proto_err_sticky", {31'd0, proto_err}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
